// File: rtl/soc_evt_prop_pkg.sv
// Shared types and defaults for the SoC-side event propagator.
// Holds the per-channel handshake state encoding and the default synchronizer depth.
package soc_evt_prop_pkg;

   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      WAIT_LOW
   } evt_tx_state_e;

endpackage

// File: rtl/soc_evt_tx_channel.sv
// One event channel: ack synchronizer, saturating pending counter, sticky overflow flag
// and the 4-phase valid/ack handshake FSM.
module soc_evt_tx_channel
   import soc_evt_prop_pkg::*;
#(
   parameter int CNT_WIDTH   = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic evt_i,
   input  logic ack_i,
   input  logic ovf_clr_i,
   output logic valid_o,
   output logic ovf_o,
   output logic busy_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   evt_tx_state_e          state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;
   logic                   dec;
   logic                   ovf_set;

   // Ack arrives from another clock domain; the FSM only ever sees the last stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dec     = (state_q == IDLE) && (cnt_q != '0);
      case (state_q)
         IDLE:     if (dec) state_d = REQ;
         REQ:      state_d = WAIT_ACK;
         WAIT_ACK: if (ack_s) state_d = WAIT_LOW;
         WAIT_LOW: if (!ack_s) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // Valid is registered from the next state so it lines up with REQ/WAIT_ACK.
      valid_d = (state_d == REQ) || (state_d == WAIT_ACK);
   end

   // A pulse arriving together with a dispatch cancels out; a pulse at max is lost.
   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      if (evt_i && !dec) begin
         if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (dec && !evt_i) begin
         cnt_d = cnt_q - 1'b1;
      end
      ovf_d = ovf_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign ovf_o   = ovf_q;
   assign busy_o  = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: rtl/soc_evt_propagator_tx.sv
// SoC-domain transmitter for single-cycle event pulses over independent 4-phase handshakes.
// Instantiates one channel per event bit and provides a registered aggregate busy flag.
module soc_evt_propagator_tx
   import soc_evt_prop_pkg::*;
#(
   parameter int NUM_EVT     = 4,
   parameter int CNT_WIDTH   = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_EVT-1:0] evt_i,
   output logic [NUM_EVT-1:0] evt_valid_o,
   input  logic [NUM_EVT-1:0] evt_ack_i,
   input  logic               ovf_clr_i,
   output logic [NUM_EVT-1:0] ovf_o,
   output logic               busy_o
);

   logic [NUM_EVT-1:0] ch_busy;
   logic               busy_q;

   for (genvar i = 0; i < NUM_EVT; i++) begin : g_ch
      soc_evt_tx_channel #(
         .CNT_WIDTH  (CNT_WIDTH),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .evt_i    (evt_i[i]),
         .ack_i    (evt_ack_i[i]),
         .ovf_clr_i(ovf_clr_i),
         .valid_o  (evt_valid_o[i]),
         .ovf_o    (ovf_o[i]),
         .busy_o   (ch_busy[i])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= |ch_busy;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_soc_evt_propagator_tx.sv
// Self-checking bench for soc_evt_propagator_tx: directed scenarios plus randomized traffic
// compared against a timing-level reference model of dispatches and pending counts.
module tb_soc_evt_propagator_tx;

   localparam int NUM_EVT     = 4;
   localparam int CNT_WIDTH   = 4;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
   localparam int HS_PERIOD   = 2 * SYNC_STAGES + 3;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic [NUM_EVT-1:0] evt_i = '0;
   logic [NUM_EVT-1:0] evt_valid_o;
   logic [NUM_EVT-1:0] evt_ack_i;
   logic               ovf_clr_i = 1'b0;
   logic [NUM_EVT-1:0] ovf_o;
   logic               busy_o;

   logic [NUM_EVT-1:0] ack_loop = '1;
   logic [NUM_EVT-1:0] ack_man  = '0;

   always #5 clk_i = ~clk_i;

   // Remote side: either a zero-delay loopback of valid or a level the bench drives by hand.
   assign evt_ack_i = (evt_valid_o & ack_loop) | (ack_man & ~ack_loop);

   soc_evt_propagator_tx #(
      .NUM_EVT    (NUM_EVT),
      .CNT_WIDTH  (CNT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .evt_i      (evt_i),
      .evt_valid_o(evt_valid_o),
      .evt_ack_i  (evt_ack_i),
      .ovf_clr_i  (ovf_clr_i),
      .ovf_o      (ovf_o),
      .busy_o     (busy_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Handshake monitor: counts request launches and the tightest launch spacing per channel.
   int                 ncyc = 0;
   int                 hs_cnt[NUM_EVT]    = '{default: 0};
   int                 last_rise[NUM_EVT] = '{default: -1000};
   int                 min_gap[NUM_EVT]   = '{default: 1000000};
   logic [NUM_EVT-1:0] valid_prev = '0;

   always @(negedge clk_i) begin
      ncyc++;
      for (int ch = 0; ch < NUM_EVT; ch++) begin
         if (evt_valid_o[ch] === 1'b1 && valid_prev[ch] !== 1'b1) begin
            hs_cnt[ch]++;
            if (ncyc - last_rise[ch] < min_gap[ch]) min_gap[ch] = ncyc - last_rise[ch];
            last_rise[ch] = ncyc;
         end
      end
      valid_prev = evt_valid_o;
   end

   // Reference model: a dispatch occupies a channel for HS_PERIOD cycles under loopback,
   // with valid high for the dispatch cycle plus SYNC_STAGES more.
   int   edge_n = 0;
   bit   model_en = 1'b1;
   int   m_cnt[NUM_EVT];
   int   m_free[NUM_EVT];
   int   m_disp[NUM_EVT];
   bit   m_ovf[NUM_EVT];
   bit   m_valid[NUM_EVT];
   bit   m_busy_exp;
   bit   m_busy_next;

   task automatic model_edge(input logic [NUM_EVT-1:0] evt, input logic clr, input logic rst);
      bit busy_now;
      busy_now = 1'b0;
      if (rst) begin
         for (int ch = 0; ch < NUM_EVT; ch++) begin
            m_cnt[ch]  = 0;
            m_free[ch] = edge_n + 1;
            m_disp[ch] = -100;
            m_ovf[ch]  = 1'b0;
         end
         m_busy_exp  = 1'b0;
         m_busy_next = 1'b0;
      end else begin
         m_busy_exp = m_busy_next;
         for (int ch = 0; ch < NUM_EVT; ch++) begin
            bit dispatch;
            bit lost;
            dispatch = (edge_n >= m_free[ch]) && (m_cnt[ch] > 0);
            lost     = 1'b0;
            if (dispatch) begin
               m_disp[ch] = edge_n;
               m_free[ch] = edge_n + HS_PERIOD;
            end
            if (evt[ch] && !dispatch) begin
               if (m_cnt[ch] == CNT_MAX) lost = 1'b1;
               else m_cnt[ch]++;
            end else if (dispatch && !evt[ch]) begin
               m_cnt[ch]--;
            end
            if (lost) m_ovf[ch] = 1'b1;
            else if (clr) m_ovf[ch] = 1'b0;
            busy_now = busy_now || (m_cnt[ch] != 0) || (edge_n + 1 < m_free[ch]);
         end
         m_busy_next = busy_now;
      end
      for (int ch = 0; ch < NUM_EVT; ch++) begin
         m_valid[ch] = (edge_n >= m_disp[ch]) && (edge_n <= m_disp[ch] + SYNC_STAGES);
      end
      edge_n++;
   endtask

   task automatic apply_stimulus(input logic [NUM_EVT-1:0] evt, input logic clr, input logic rst);
      @(negedge clk_i);
      evt_i     = evt;
      ovf_clr_i = clr;
      rst_i     = rst;
      @(posedge clk_i);
      #1;
      if (model_en) begin
         model_edge(evt, clr, rst);
         for (int ch = 0; ch < NUM_EVT; ch++) begin
            check_output($sformatf("valid[%0d]@%0d", ch, edge_n - 1), evt_valid_o[ch], m_valid[ch]);
            check_output($sformatf("ovf[%0d]@%0d", ch, edge_n - 1), ovf_o[ch], m_ovf[ch]);
         end
         check_output($sformatf("busy@%0d", edge_n - 1), busy_o, m_busy_exp);
      end else begin
         edge_n++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) apply_stimulus('0, 1'b0, 1'b0);
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k;
      k = 0;
      while (busy_o !== 1'b0 && k < bound) begin
         apply_stimulus('0, 1'b0, 1'b0);
         k++;
      end
      check_output({tag, "_drained"}, busy_o, 0);
   endtask

   initial begin
      int  base;
      bit  rose;

      // Reset state
      apply_stimulus('0, 1'b0, 1'b1);
      check_output("reset_valid", evt_valid_o, 0);
      check_output("reset_ovf", ovf_o, 0);
      check_output("reset_busy", busy_o, 0);
      idle(3);

      // Single pulse on ch0, looped back
      base = hs_cnt[0];
      apply_stimulus(4'b0001, 1'b0, 1'b0);
      idle(20);
      check_output("ch0_single_hs", hs_cnt[0] - base, 1);
      check_output("ch0_single_busy", busy_o, 0);

      // Three back-to-back pulses on ch1
      base = hs_cnt[1];
      for (int k = 0; k < 3; k++) apply_stimulus(4'b0010, 1'b0, 1'b0);
      idle(40);
      check_output("ch1_burst_hs", hs_cnt[1] - base, 3);
      check_output("ch1_burst_gap", min_gap[1], HS_PERIOD);

      // Pulse coinciding with an IDLE dispatch of count=1
      base = hs_cnt[0];
      apply_stimulus(4'b0001, 1'b0, 1'b0);
      apply_stimulus(4'b0001, 1'b0, 1'b0);
      idle(30);
      check_output("ch0_coincide_hs", hs_cnt[0] - base, 2);

      // Saturation on ch2 with the remote ack held low
      model_en    = 1'b0;
      ack_loop[2] = 1'b0;
      ack_man[2]  = 1'b0;
      base = hs_cnt[2];
      for (int k = 0; k < 20; k++) apply_stimulus(4'b0100, 1'b0, 1'b0);
      check_output("ch2_sat_ovf", ovf_o[2], 1);
      check_output("ch2_sat_valid", evt_valid_o[2], 1);
      check_output("ch2_sat_busy", busy_o, 1);
      apply_stimulus(4'b0100, 1'b1, 1'b0);
      check_output("ch2_set_beats_clr", ovf_o[2], 1);
      apply_stimulus('0, 1'b1, 1'b0);
      check_output("ch2_clr", ovf_o[2], 0);
      apply_stimulus('0, 1'b0, 1'b0);
      check_output("ch2_clr_sticky", ovf_o[2], 0);
      ack_loop[2] = 1'b1;
      wait_idle("ch2", 400);
      check_output("ch2_sat_hs", hs_cnt[2] - base, CNT_MAX + 1);
      check_output("ch2_ovf_after", ovf_o[2], 0);

      // Reset while ch3 sits in WAIT_ACK with ack high
      ack_loop[3] = 1'b0;
      ack_man[3]  = 1'b0;
      apply_stimulus(4'b1000, 1'b0, 1'b0);
      idle(3);
      check_output("ch3_wait_ack_valid", evt_valid_o[3], 1);
      ack_man[3] = 1'b1;
      apply_stimulus(4'b1000, 1'b0, 1'b0);
      apply_stimulus('0, 1'b0, 1'b1);
      check_output("ch3_rst_valid", evt_valid_o[3], 0);
      check_output("ch3_rst_busy", busy_o, 0);
      for (int k = 0; k < 6; k++) begin
         apply_stimulus('0, 1'b0, 1'b0);
         check_output($sformatf("ch3_post_rst_idle%0d", k), {evt_valid_o[3], busy_o}, 0);
      end
      apply_stimulus(4'b1000, 1'b0, 1'b0);
      apply_stimulus('0, 1'b0, 1'b0);
      check_output("ch3_stale_req", evt_valid_o[3], 1);
      idle(2);
      check_output("ch3_stale_drop", evt_valid_o[3], 0);
      apply_stimulus(4'b1000, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) begin
         apply_stimulus('0, 1'b0, 1'b0);
         check_output($sformatf("ch3_hold_low%0d", k), {evt_valid_o[3], busy_o}, 1);
      end
      ack_man[3] = 1'b0;
      rose = 1'b0;
      for (int k = 0; k < 20 && !rose; k++) begin
         apply_stimulus('0, 1'b0, 1'b0);
         rose = (evt_valid_o[3] === 1'b1);
      end
      check_output("ch3_req_after_low", rose, 1);
      ack_loop[3] = 1'b1;
      wait_idle("ch3", 100);

      // Randomized traffic on all channels with loopback
      ack_loop = '1;
      ack_man  = '0;
      model_en = 1'b1;
      apply_stimulus('0, 1'b0, 1'b1);
      for (int k = 0; k < 800; k++) begin
         apply_stimulus(NUM_EVT'($urandom & $urandom), ($urandom_range(0, 15) == 0), 1'b0);
      end
      idle(200);
      check_output("rand_drained", busy_o, 0);
      for (int ch = 0; ch < NUM_EVT; ch++) begin
         check_output($sformatf("min_gap_ok[%0d]", ch), (min_gap[ch] >= HS_PERIOD), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
